uart_rx_frontend: RTL and testbench
===================================

# uart_rx_frontend

Receive front end for the CPU's UART peripheral. It samples the asynchronous serial line with 16x oversampling and reassembles 8N1 frames, or 8E1 frames when parity is compiled in. It presents each received byte to the peripheral register block through a sticky valid flag that a read-acknowledge pulse clears. It sits between the board's `UART_RX` pin and the peripheral's RX data/status registers, in the `sysclk` domain.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `DIV`, CLK_FREQ/(BAUD*16) with integer floor (651 at defaults), clock cycles per oversample tick. Must be ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `rx_in`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rd_ack`  in  1  one-cycle pulse: CPU has read `rx_data`; clears `rx_valid`, `overrun`, `frame_err`, `parity_err`.
- `rx_data`  out  8  last committed byte.
- `rx_valid`  out  1  sticky: an unread byte is present.
- `rx_irq`  out  1  one-cycle pulse on each byte commit.
- `overrun`  out  1  sticky: a byte was committed while `rx_valid` was already 1.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `parity_err`  out  1  sticky: parity mismatch. Tied 0 without the macro.

## Operation
- Input conditioning: two-flop synchronizer feeding a third history flop. A falling edge is `sync`=0 with `hist`=1. All sampling uses `sync`.
- Tick generator: free-running counter 0..DIV-1. `tick` is high for one cycle when the count is DIV-1, then the counter wraps to 0.
- Sub-bit counter `os` is 4 bits, counts ticks, and is cleared on every state entry.
- FSM, encoded in 3 bits:
  - IDLE: on a falling edge go to START and clear `os`.
  - START: on the tick where `os`=7 (mid start bit), go to DATA if `sync`=0; otherwise the start was false and the FSM returns to IDLE.
  - DATA: on every tick where `os`=15, shift `sync` into the shift register LSB-first and increment the bit index. After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: at `os`=15, compute `perr` = XOR(shift[7:0], `sync`) and go to STOP.
  - STOP: at `os`=15, sample the stop bit, then go to IDLE.
    - If `sync`=1: commit. `rx_data` ← shift register, `rx_valid`←1, `rx_irq` pulses, `parity_err`←`perr`.
    - If `sync`=0: no commit. Set `frame_err`; `rx_data` and `rx_valid` are unchanged.
- Overrun: a commit while `rx_valid`=1 sets `overrun` and still overwrites `rx_data`.
- Ack and commit in the same cycle: the commit wins. `rx_valid` stays 1; `overrun`, `frame_err` and `parity_err` are cleared, and then `parity_err` is reloaded from this frame.
- Ack with nothing pending has no effect.
- Break condition (line held low): produces one `frame_err`. No new start is accepted until the line has returned high, because starts require a falling edge.

## Timing
- Reset values: `rx_data`=0x00, all flags 0, `rx_irq`=0, FSM in IDLE, all counters 0, synchronizer flops 1.
- Reset mid-frame aborts the frame immediately. Nothing is committed.
- Start detection latency is 3 clk from the `rx_in` edge (synchronizer plus history flop), plus up to one tick of jitter. That jitter is ≤1/16 bit.
- Sampling points fall at 8/16 of the start bit, then 24/16, 40/16 … of the frame.
- Commit: `rx_valid`, `rx_data` and `rx_irq` update on the clk edge after the stop-sample tick. That is 9.5 bit times (10.5 with parity) plus ~3 clk after the start edge.
- `rd_ack` takes effect on the next clk edge.
- Back-to-back frames are supported: the FSM is in IDLE by the middle of the stop bit.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is 8E1, the PARITY state exists, and `parity_err` is live. A byte with a parity error is still committed.
  - Undefined: frame is 8N1, the PARITY state is removed, and `parity_err` is constant 0.

## Test plan
All scenarios use bench parameters CLK_FREQ=1_600_000, BAUD=10_000, giving DIV=10 and 160 clk/bit.
- Reset then idle line for 2000 clk → all outputs 0, no `rx_irq`.
- Send 0xA5 8N1 → `rx_data`=0xA5, `rx_valid`=1, one `rx_irq` pulse about 1523 clk after the start edge. `rd_ack` → `rx_valid`=0 next cycle.
- 40-clk low glitch on an idle line → no commit, FSM back in IDLE, no flags set.
- Send 0x3C then 0x5A back-to-back without ack → `rx_data`=0x5A, `overrun`=1. `rd_ack` clears both flags.
- Send 0x81 with the stop bit forced low → `frame_err`=1, `rx_valid`=0, `rx_data` unchanged. Then hold the line low for 3 bit times, release it, and send 0x11 → 0x11 is received correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong, expected 1) → `rx_data`=0x07, `parity_err`=1. Assert `rd_ack` and assert mid-frame reset → all outputs 0.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//
// Receive front end for the CPU UART peripheral. The block samples the
// asynchronous serial line at 16x the bit rate and rebuilds 8N1 frames, or
// 8E1 frames when UART_RX_PARITY_EN is defined. Each received byte goes to
// the peripheral register block through a sticky valid flag. A read-acknowledge
// pulse clears that flag.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : 8E1 frames, PARITY state present, parity_err is live
//   undefined : 8N1 frames, no PARITY state, parity_err tied 0
//
// Parameters
//   CLK_FREQ  clock frequency in Hz
//   BAUD      line rate in bit/s
//   DIV       clk cycles per oversample tick, floor(CLK_FREQ/(BAUD*16)), >= 2
//
// Ports
//   clk         clock
//   reset       asynchronous, active-low reset
//   rx_in       raw serial line, idle high, asynchronous to clk
//   rd_ack      one-cycle pulse: CPU has read rx_data, clears sticky flags
//   rx_data     last committed byte
//   rx_valid    sticky: an unread byte is present
//   rx_irq      one-cycle pulse on each byte commit
//   overrun     sticky: a byte was committed while rx_valid was already 1
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch on the last committed byte

module uart_rx_frontend #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_irq,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_frontend: DIV must be at least 2");
  end

  localparam int unsigned     CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Input conditioning
  logic sync1_q, sync2_q, hist_q;
  logic fall;

  // Oversample tick generator
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  // Frame state
  logic [2:0] state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bitidx_q, bitidx_d;
  logic [7:0] shift_q, shift_d;

  // Register-block facing state
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       irq_q, irq_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;         // parity result of the frame in flight
  logic perr_flag_q, perr_flag_d;
`endif

  // A start is only a falling edge, so a line stuck low cannot retrigger.
  assign fall = ~sync2_q & hist_q;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    irq_d    = 1'b0;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d      = perr_q;
    perr_flag_d = perr_flag_q;
`endif

    // Ack clears first; a commit later in this block then overrides it,
    // so a commit in the same cycle as an ack wins.
    if (rd_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_flag_d = 1'b0;
`endif
    end

    if (tick) begin
      os_d = os_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        os_d = '0;
        if (fall) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick && os_q == 4'd7) begin
          os_d     = '0;
          bitidx_d = '0;
          state_d  = sync2_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (tick && os_q == 4'd15) begin
          os_d     = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && os_q == 4'd15) begin
          os_d    = '0;
          perr_d  = ^{shift_q, sync2_q};
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick && os_q == 4'd15) begin
          os_d    = '0;
          state_d = S_IDLE;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            irq_d   = 1'b1;
            // An ack in this cycle consumed the old byte, so no overrun.
            if (valid_q && !rd_ack) begin
              ovr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_flag_d = perr_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        os_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 1'b1;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      os_q     <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_flag_q <= 1'b0;
`endif
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      os_q     <= os_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
      perr_flag_q <= perr_flag_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_irq    = irq_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_flag_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend
//
// Directed bench for uart_rx_frontend at CLK_FREQ=1_600_000, BAUD=10_000
// (DIV=10, 160 clk per bit). A frame-level model holds the expected
// register-block outputs. It changes only on frame completion, on ack and on
// reset. A compare process checks the DUT against the model on every falling
// clk edge. The exception is a short window around each stop-bit sample,
// where the commit instant carries up to one tick of jitter. Literal checks
// pin the model at key points. Build with +define+UART_RX_PARITY_EN to
// exercise 8E1.

module tb_uart_rx_frontend;

  localparam int unsigned BITT = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR  = 1'b1;
`else
  localparam bit          PAR  = 1'b0;
`endif
  // Earliest stop-sample edge, in clk cycles after the start edge.
  localparam int unsigned LAT_MIN = 1514 + (PAR ? BITT : 0);

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_in  = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_irq, overrun, frame_err, parity_err;

  uart_rx_frontend #(
    .CLK_FREQ(1_600_000),
    .BAUD    (10_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_irq    (rx_irq),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Frame-level model of the register-block outputs
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_perr  = 1'b0;

  bit          settle  = 1'b0;
  int          irq_cnt = 0;
  int unsigned irq_cyc = 0;

  always @(negedge clk) begin
    if (settle) begin
      if (rx_irq) begin
        irq_cnt = irq_cnt + 1;
        irq_cyc = cyc;
      end
    end else begin
      checks = checks + 1;
      if ({rx_data, rx_valid, rx_irq, overrun, frame_err, parity_err} !==
          {m_data, m_valid, 1'b0, m_ovr, m_ferr, m_perr}) begin
        failures = failures + 1;
        $display("FAIL cycle_compare cyc=%0d got data=%h v=%b irq=%b ovr=%b ferr=%b perr=%b want data=%h v=%b irq=0 ovr=%b ferr=%b perr=%b",
                 cyc, rx_data, rx_valid, rx_irq, overrun, frame_err, parity_err,
                 m_data, m_valid, m_ovr, m_ferr, m_perr);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic clocks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    clocks(1);
    rd_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Drives one frame; par is only sent in the 8E1 build. The stop bit is
  // driven for a full bit time, so frames can be chained back-to-back.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par);
    int unsigned c0;
    bit          perr_exp;
    perr_exp = PAR ? (par != ^d) : 1'b0;
    c0 = cyc;
    rx_in = 1'b0;
    clocks(BITT);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      clocks(BITT);
    end
    if (PAR) begin
      rx_in = par;
      clocks(BITT);
    end
    rx_in = stop;
    clocks(70);
    irq_cnt = 0;
    settle  = 1'b1;
    clocks(30);
    settle  = 1'b0;
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_data  = d;
      m_valid = 1'b1;
      m_perr  = perr_exp;
      chk("irq_count", 16'(irq_cnt), 16'd1);
      if (irq_cyc - c0 < LAT_MIN - 2 || irq_cyc - c0 > LAT_MIN + 11) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL commit_latency got=%0d want=%0d..%0d", irq_cyc - c0, LAT_MIN - 2, LAT_MIN + 11);
      end else begin
        checks = checks + 1;
      end
    end else begin
      m_ferr = 1'b1;
      chk("irq_count_noncommit", 16'(irq_cnt), 16'd0);
    end
    clocks(BITT - 100);
  endtask

  initial begin
    #1 reset = 1'b0;
    model_reset();
    clocks(5);
    chk("reset_data", 16'(rx_data), 16'h00);
    chk("reset_valid", 16'(rx_valid), 16'd0);
    reset = 1'b1;

    // Idle line
    clocks(2000);
    chk("idle_valid", 16'(rx_valid), 16'd0);
    chk("idle_flags", {13'd0, overrun, frame_err, parity_err}, 16'd0);

    // Single byte, correct parity
    send_frame(8'hA5, 1'b1, ^(8'hA5));
    chk("a5_data", 16'(rx_data), 16'hA5);
    chk("a5_valid", 16'(rx_valid), 16'd1);
    ack();
    chk("a5_ack_valid", 16'(rx_valid), 16'd0);

    // 40-clk glitch: false start, then idle
    rx_in = 1'b0;
    clocks(40);
    rx_in = 1'b1;
    clocks(2000);
    chk("glitch_valid", 16'(rx_valid), 16'd0);
    chk("glitch_flags", {13'd0, overrun, frame_err, parity_err}, 16'd0);

    // Back-to-back without ack: overrun
    send_frame(8'h3C, 1'b1, ^(8'h3C));
    send_frame(8'h5A, 1'b1, ^(8'h5A));
    chk("b2b_data", 16'(rx_data), 16'h5A);
    chk("b2b_overrun", 16'(overrun), 16'd1);
    ack();
    chk("b2b_ack_valid", 16'(rx_valid), 16'd0);
    chk("b2b_ack_overrun", 16'(overrun), 16'd0);

    // Ack with nothing pending
    clocks(20);
    ack();
    clocks(20);
    chk("idle_ack_data", 16'(rx_data), 16'h5A);

    // Stop bit low, then break, then recovery
    send_frame(8'h81, 1'b0, ^(8'h81));
    chk("ferr_flag", 16'(frame_err), 16'd1);
    chk("ferr_valid", 16'(rx_valid), 16'd0);
    chk("ferr_data", 16'(rx_data), 16'h5A);
    clocks(3 * BITT);
    rx_in = 1'b1;
    clocks(2 * BITT);
    send_frame(8'h11, 1'b1, ^(8'h11));
    chk("after_break_data", 16'(rx_data), 16'h11);
    chk("after_break_valid", 16'(rx_valid), 16'd1);
    ack();

    // Wrong parity bit (0x07 needs 1 for even parity)
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_data", 16'(rx_data), 16'h07);
    chk("par_err", 16'(parity_err), PAR ? 16'd1 : 16'd0);
    ack();
    chk("par_ack_err", 16'(parity_err), 16'd0);

    // Leave a byte pending, then abort a frame with reset
    send_frame(8'h66, 1'b1, ^(8'h66));
    chk("pre_reset_data", 16'(rx_data), 16'h66);
    rx_in = 1'b0;
    clocks(BITT);
    rx_in = 1'b1;
    clocks(2 * BITT + 37);
    reset = 1'b0;
    model_reset();
    clocks(4);
    chk("midreset_data", 16'(rx_data), 16'h00);
    chk("midreset_flags", {11'd0, rx_valid, rx_irq, overrun, frame_err, parity_err}, 16'd0);
    reset = 1'b1;
    clocks(2000);
    chk("post_reset_valid", 16'(rx_valid), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
